// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one N-bit ripple adder among NREQ requesters, with a single registered response slot.
// Define ADDER_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.

module adder_arbiter_rca #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);
  logic [N:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]    = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[N];
endmodule

module adder_arbiter #(
  parameter  int N    = 4,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*N-1:0] req_a_i,
  input  logic [NREQ*N-1:0] req_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [IDW-1:0]  rsp_id_o,
  output logic [N-1:0]    rsp_sum_o,
  output logic            rsp_carry_o
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t         state_q, state_d;
  logic           can_accept, any_valid, accept;
  logic [IDW-1:0] winner;
  logic [N-1:0]   a_sel, b_sel, sum;
  logic           carry;
  logic [IDW-1:0] rsp_id_q;
  logic [N-1:0]   rsp_sum_q;
  logic           rsp_carry_q;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest-index valid requester is the last (winning) assignment.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[IDW'(k)]) begin
        any_valid = 1'b1;
        winner    = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] cand;
  int             rr_idx;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    rr_idx    = 0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_idx = int'(last_grant_q) + i;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      cand = IDW'(rr_idx);
      if (!any_valid && req_valid_i[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end
`endif

  assign can_accept  = (state_q == S_EMPTY) || rsp_ready_i;
  assign accept      = !rst_i && can_accept && any_valid;
  assign req_ready_o = accept ? (NREQ'(1) << winner) : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == IDW'(k)) begin
        a_sel = req_a_i[k*N +: N];
        b_sel = req_b_i[k*N +: N];
      end
    end
  end

  adder_arbiter_rca #(.N(N)) u_adder (
    .a_i     (a_sel),
    .b_i     (b_sel),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // A drain with a simultaneous accept keeps the slot full with the new result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (!accept && rsp_ready_i) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_EMPTY;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      last_grant_q <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_id_q     <= winner;
        rsp_sum_q    <= sum;
        rsp_carry_q  <= carry;
`ifndef ADDER_ARB_FIXED_PRIO_EN
        last_grant_q <= winner;
`endif
      end
    end
  end

  assign rsp_valid_o = (state_q == S_FULL);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_carry_o = rsp_carry_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed scenarios followed by randomized traffic against a queue-based reference model.
// Expected grant orders follow ADDER_ARB_FIXED_PRIO_EN when it is defined.

module tb_adder_arbiter;
  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*N-1:0] req_a_i;
  logic [NREQ*N-1:0] req_b_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [IDW-1:0]    rsp_id_o;
  logic [N-1:0]      rsp_sum_o;
  logic              rsp_carry_o;

  always #5 clk = ~clk;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_carry_o (rsp_carry_o)
  );

  typedef struct {
    int         id;
    logic [N:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   dut_grants[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: pending requests, priority pointer, slot occupancy.
  bit         pend[NREQ];
  logic [N-1:0] pa[NREQ];
  logic [N-1:0] pb[NREQ];
  int         last_m;
  bit         full_m;
  bit         rdy_m;
  bit         rst_m;
  bit         keep_valid;
  int         new_pct;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int model_winner();
    int k;
    for (int j = 1; j <= NREQ; j++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      k = j - 1;
`else
      k = (last_m + j) % NREQ;
`endif
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  function automatic int grant_at(int i);
    return (i < dut_grants.size()) ? dut_grants[i] : -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = full_m;
    for (int k = 0; k < NREQ; k++) b = b | pend[k];
    return b;
  endfunction

  task automatic drive();
    rst_i       = rst_m;
    rsp_ready_i = rdy_m;
    for (int k = 0; k < NREQ; k++) begin
      req_valid_i[k]       = pend[k];
      req_a_i[k*N +: N]    = pa[k];
      req_b_i[k*N +: N]    = pb[k];
    end
  endtask

  task automatic new_req(int k);
    pend[k] = 1'b1;
    pa[k]   = N'($urandom);
    pb[k]   = N'($urandom);
  endtask

  // One clock cycle: drive, check the grant at negedge, advance the model at posedge.
  task automatic step();
    int              w;
    logic [NREQ-1:0] want;
    drive();
    @(negedge clk);
    w    = model_winner();
    want = '0;
    if (!rst_m && (!full_m || rdy_m) && w >= 0) want[w] = 1'b1;
    check("req_ready", 32'(req_ready_o), 32'(want));
    for (int k = 0; k < NREQ; k++)
      if (req_ready_o[k]) dut_grants.push_back(k);
    @(posedge clk);
    if (rst_m) begin
      full_m = 1'b0;
      last_m = NREQ - 1;
      exp_q.delete();
    end else if (want != '0) begin
      exp_q.push_back('{w, {1'b0, pa[w]} + {1'b0, pb[w]}});
      last_m = w;
      full_m = 1'b1;
      if (keep_valid) new_req(w);
      else pend[w] = 1'b0;
    end else if (full_m && rdy_m) begin
      full_m = 1'b0;
    end
    for (int k = 0; k < NREQ; k++)
      if (!pend[k] && $urandom_range(99) < new_pct) new_req(k);
    #1;
  endtask

  task automatic drain();
    keep_valid = 1'b0;
    new_pct    = 0;
    rdy_m      = 1'b1;
    rst_m      = 1'b0;
    for (int i = 0; i < 20 && busy(); i++) step();
  endtask

  // Monitor: compares the presented response against the scoreboard head, pops on handshake.
  always @(negedge clk) begin
    if (rst_i === 1'b0) begin
      check("rsp_valid", 32'(rsp_valid_o), 32'(exp_q.size() != 0));
      if (rsp_valid_o && exp_q.size() != 0) begin
        check("rsp_id", 32'(rsp_id_o), 32'(exp_q[0].id));
        check("rsp_sum", 32'(rsp_sum_o), 32'(exp_q[0].res[N-1:0]));
        check("rsp_carry", 32'(rsp_carry_o), 32'(exp_q[0].res[N]));
        if (rsp_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int exp_fair[6];
    int exp_alt[4];
    int exp_bp;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    exp_fair = '{0, 0, 0, 0, 0, 0};
    exp_alt  = '{1, 1, 1, 1};
    exp_bp   = 1;
`else
    exp_fair = '{0, 1, 2, 3, 0, 1};
    exp_alt  = '{1, 3, 1, 3};
    exp_bp   = 3;
`endif
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b0;
      pa[k]   = '0;
      pb[k]   = '0;
    end
    last_m     = NREQ - 1;
    full_m     = 1'b0;
    rdy_m      = 1'b1;
    rst_m      = 1'b1;
    keep_valid = 1'b0;
    new_pct    = 0;

    // Reset with every requester valid, then fairness under full load.
    for (int k = 0; k < NREQ; k++) new_req(k);
    step();
    step();
    check("reset_valid", 32'(rsp_valid_o), 0);
    check("reset_id", 32'(rsp_id_o), 0);
    check("reset_sum", 32'(rsp_sum_o), 0);
    check("reset_carry", 32'(rsp_carry_o), 0);
    rst_m      = 1'b0;
    keep_valid = 1'b1;
    dut_grants.delete();
    repeat (6) step();
    for (int i = 0; i < 6; i++) check("fair_grant", 32'(grant_at(i)), 32'(exp_fair[i]));

    // Single request, including the all-ones boundary.
    drain();
    pend[2] = 1'b1; pa[2] = 4'h9; pb[2] = 4'h8;
    step();
    check("single_valid", 32'(rsp_valid_o), 1);
    check("single_id", 32'(rsp_id_o), 2);
    check("single_sum", 32'(rsp_sum_o), 32'h1);
    check("single_carry", 32'(rsp_carry_o), 1);
    pend[2] = 1'b1; pa[2] = 4'hF; pb[2] = 4'hF;
    step();
    check("ones_sum", 32'(rsp_sum_o), 32'hE);
    check("ones_carry", 32'(rsp_carry_o), 1);

    // Back-pressure with slot full from requester 1.
    drain();
    new_req(1);
    step();
    rdy_m = 1'b0;
    new_req(1);
    new_req(3);
    repeat (3) step();
    check("bp_hold_id", 32'(rsp_id_o), 1);
    rdy_m = 1'b1;
    dut_grants.delete();
    step();
    check("bp_release_grant", 32'(grant_at(0)), 32'(exp_bp));
    check("bp_release_id", 32'(rsp_id_o), 32'(exp_bp));

    // Reset while full: pending response dropped, pointer restored.
    drain();
    new_req(2);
    step();
    rst_m = 1'b1;
    rdy_m = 1'b0;
    new_req(0);
    new_req(3);
    step();
    rst_m = 1'b0;
    check("midreset_valid", 32'(rsp_valid_o), 0);
    rdy_m = 1'b1;
    dut_grants.delete();
    step();
    check("midreset_grant", 32'(grant_at(0)), 0);

    // Requesters 1 and 3 held valid.
    drain();
    new_req(1);
    new_req(3);
    keep_valid = 1'b1;
    dut_grants.delete();
    repeat (4) step();
    for (int i = 0; i < 4; i++) check("alt_grant", 32'(grant_at(i)), 32'(exp_alt[i]));

    // Randomized traffic with back-pressure and occasional reset.
    drain();
    new_pct = 35;
    for (int i = 0; i < 1500; i++) begin
      rdy_m = ($urandom_range(99) < 70);
      rst_m = ($urandom_range(199) == 0);
      step();
    end
    drain();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
